// File: rtl/ball_grid_scanner.sv
// Renders the ball position plus a short trail into an ASCII grid and
// streams it out one row per handshake, top row first.
module ball_grid_scanner #(
    parameter int         GRID_W      = 16,
    parameter int         GRID_H      = 16,
    parameter int         TRAIL_DEPTH = 2,
    parameter logic [7:0] CHAR_BALL   = 8'h6F,
    parameter logic [7:0] CHAR_TRAIL  = 8'h2E,
    parameter logic [7:0] CHAR_EMPTY  = 8'h5F
) (
    input  logic                clk_50,
    input  logic                reset_n,
    input  logic                pos_valid,
    output logic                pos_ready,
    input  logic [3:0]          ball_position_x,
    input  logic [3:0]          ball_position_y,
    output logic                row_valid,
    input  logic                row_ready,
    output logic [3:0]          row_index,
    output logic [GRID_W*8-1:0] row_data,
    output logic                frame_done,
    output logic [7:0]          frame_count
);

    localparam int         TN      = (TRAIL_DEPTH > 0) ? TRAIL_DEPTH : 1;
    localparam logic [3:0] TOP_ROW = 4'(GRID_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN
    } state_t;

    state_t state, state_next;

    logic                pos_ready_next;
    logic                row_valid_next;
    logic [3:0]          row_index_next;
    logic [GRID_W*8-1:0] row_data_next;
    logic                frame_done_next;
    logic [7:0]          frame_count_next;

    logic [3:0] snap_x, snap_y, snap_x_next, snap_y_next;
    logic       snap_valid, snap_valid_next;

    logic [3:0]    trail_x [TN];
    logic [3:0]    trail_y [TN];
    logic [3:0]    trail_x_next [TN];
    logic [3:0]    trail_y_next [TN];
    logic [TN-1:0] trail_valid, trail_valid_next;

    logic [3:0]          render_row;
    logic [GRID_W*8-1:0] render_data;

    // Row about to be registered: the top row on LOAD, else the one below.
    assign render_row = (state == LOAD) ? TOP_ROW : row_index - 4'd1;

    for (genvar gx = 0; gx < GRID_W; gx++) begin : g_col
        logic ball_hit;
        logic trail_hit;

        always_comb begin
            ball_hit  = snap_valid && (snap_x == 4'(gx))
                        && (snap_y == render_row);
            trail_hit = 1'b0;
            for (int i = 0; i < TRAIL_DEPTH; i++) begin
                if (trail_valid[i] && (trail_x[i] == 4'(gx))
                    && (trail_y[i] == render_row)) begin
                    trail_hit = 1'b1;
                end
            end
        end

        assign render_data[gx*8 +: 8] = ball_hit  ? CHAR_BALL  :
                                        trail_hit ? CHAR_TRAIL :
                                                    CHAR_EMPTY;
    end

    always_comb begin
        state_next       = state;
        pos_ready_next   = 1'b0;
        row_valid_next   = row_valid;
        row_index_next   = row_index;
        row_data_next    = row_data;
        frame_done_next  = 1'b0;
        frame_count_next = frame_count;
        snap_x_next      = snap_x;
        snap_y_next      = snap_y;
        snap_valid_next  = snap_valid;
        trail_x_next     = trail_x;
        trail_y_next     = trail_y;
        trail_valid_next = trail_valid;

        unique case (state)
            IDLE: begin
                pos_ready_next = 1'b1;
                row_valid_next = 1'b0;
                if (pos_valid && pos_ready) begin
                    trail_x_next[0]     = snap_x;
                    trail_y_next[0]     = snap_y;
                    trail_valid_next[0] = snap_valid;
                    for (int i = 1; i < TN; i++) begin
                        trail_x_next[i]     = trail_x[i-1];
                        trail_y_next[i]     = trail_y[i-1];
                        trail_valid_next[i] = trail_valid[i-1];
                    end
                    if (TRAIL_DEPTH == 0) begin
                        trail_valid_next = '0;
                    end
                    snap_x_next     = ball_position_x;
                    snap_y_next     = ball_position_y;
                    snap_valid_next = 1'b1;
                    pos_ready_next  = 1'b0;
                    state_next      = LOAD;
                end
            end
            LOAD: begin
                row_valid_next = 1'b1;
                row_index_next = TOP_ROW;
                row_data_next  = render_data;
                state_next     = SCAN;
            end
            SCAN: begin
                if (row_ready) begin
                    if (row_index != 4'd0) begin
                        row_index_next = row_index - 4'd1;
                        row_data_next  = render_data;
                    end else begin
                        row_valid_next   = 1'b0;
                        frame_done_next  = 1'b1;
                        frame_count_next = frame_count + 8'd1;
                        pos_ready_next   = 1'b1;
                        state_next       = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pos_ready   <= 1'b0;
            row_valid   <= 1'b0;
            row_index   <= 4'd0;
            row_data    <= {GRID_W{CHAR_EMPTY}};
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            snap_x      <= 4'd0;
            snap_y      <= 4'd0;
            snap_valid  <= 1'b0;
            trail_valid <= '0;
            for (int i = 0; i < TN; i++) begin
                trail_x[i] <= 4'd0;
                trail_y[i] <= 4'd0;
            end
        end else begin
            state       <= state_next;
            pos_ready   <= pos_ready_next;
            row_valid   <= row_valid_next;
            row_index   <= row_index_next;
            row_data    <= row_data_next;
            frame_done  <= frame_done_next;
            frame_count <= frame_count_next;
            snap_x      <= snap_x_next;
            snap_y      <= snap_y_next;
            snap_valid  <= snap_valid_next;
            trail_valid <= trail_valid_next;
            for (int i = 0; i < TN; i++) begin
                trail_x[i] <= trail_x_next[i];
                trail_y[i] <= trail_y_next[i];
            end
        end
    end

endmodule

// File: tb/tb_ball_grid_scanner.sv
// Directed bench for ball_grid_scanner: framing, trail history,
// back-pressure, input blocking, mid-frame reset, wrap and range.
module tb_ball_grid_scanner;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pv = 1'b0;
    logic         pr;
    logic [3:0]   px = 4'd0;
    logic [3:0]   py = 4'd0;
    logic         rv;
    logic         rr = 1'b0;
    logic [3:0]   ri;
    logic [127:0] rd;
    logic         fd;
    logic [7:0]   fc;

    logic         pv8 = 1'b0;
    logic         pr8;
    logic [3:0]   px8 = 4'd0;
    logic [3:0]   py8 = 4'd0;
    logic         rv8;
    logic         rr8 = 1'b0;
    logic [3:0]   ri8;
    logic [63:0]  rd8;
    logic         fd8;
    logic [7:0]   fc8;

    int          nvec = 0;
    int          nerr = 0;
    logic [7:0]  exp_fc = 8'd0;

    // Reference history: index 0 = snapshot, 1..2 = trail.
    int hx [3];
    int hy [3];
    bit hv [3];

    ball_grid_scanner dut (
        .clk_50(clk), .reset_n(rst_n),
        .pos_valid(pv), .pos_ready(pr),
        .ball_position_x(px), .ball_position_y(py),
        .row_valid(rv), .row_ready(rr),
        .row_index(ri), .row_data(rd),
        .frame_done(fd), .frame_count(fc)
    );

    ball_grid_scanner #(.GRID_W(8)) dut8 (
        .clk_50(clk), .reset_n(rst_n),
        .pos_valid(pv8), .pos_ready(pr8),
        .ball_position_x(px8), .ball_position_y(py8),
        .row_valid(rv8), .row_ready(rr8),
        .row_index(ri8), .row_data(rd8),
        .frame_done(fd8), .frame_count(fc8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            hx[i] = 0; hy[i] = 0; hv[i] = 1'b0;
        end
    endfunction

    function automatic void model_push(input int x, input int y);
        for (int i = 2; i > 0; i--) begin
            hx[i] = hx[i-1]; hy[i] = hy[i-1]; hv[i] = hv[i-1];
        end
        hx[0] = x; hy[0] = y; hv[0] = 1'b1;
    endfunction

    function automatic logic [127:0] exp_row(input int r);
        logic [127:0] d;
        d = {16{8'h5F}};
        for (int t = 2; t >= 1; t--) begin
            if (hv[t] && hy[t] == r && hx[t] < 16) d[hx[t]*8 +: 8] = 8'h2E;
        end
        if (hv[0] && hy[0] == r && hx[0] < 16) d[hx[0]*8 +: 8] = 8'h6F;
        return d;
    endfunction

    // Offer a sample, wait for acceptance, leave the first row visible.
    task automatic send(input int x, input int y);
        int n;
        n = 0;
        while (pr !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("send_wait_ready", pr, 1);
        pv = 1'b1;
        px = 4'(x);
        py = 4'(y);
        tick();
        pv = 1'b0;
        model_push(x, y);
        chk("accept_rv_low", rv, 0);
        chk("accept_pr_low", pr, 0);
        tick();
    endtask

    task automatic scan(input int stall_row, input int stall_n);
        rr = 1'b1;
        for (int r = 15; r >= 0; r--) begin
            chk("row_valid", rv, 1);
            chk("row_index", ri, 128'(r));
            chk("row_data", rd, exp_row(r));
            chk("pos_ready_scan", pr, 0);
            chk("done_in_scan", fd, 0);
            if (r == stall_row) begin
                rr = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    tick();
                    chk("stall_valid", rv, 1);
                    chk("stall_index", ri, 128'(r));
                    chk("stall_data", rd, exp_row(r));
                end
                rr = 1'b1;
            end
            tick();
        end
        exp_fc = exp_fc + 8'd1;
        chk("end_rv_low", rv, 0);
        chk("frame_done", fd, 1);
        chk("frame_count", fc, exp_fc);
        chk("end_pr_high", pr, 1);
        tick();
        chk("frame_done_pulse", fd, 0);
    endtask

    initial begin
        int n;
        model_clear();
        repeat (3) tick();
        chk("rst_pos_ready", pr, 0);
        chk("rst_row_valid", rv, 0);
        chk("rst_row_index", ri, 0);
        chk("rst_row_data", rd, {16{8'h5F}});
        chk("rst_frame_done", fd, 0);
        chk("rst_frame_count", fc, 0);
        rst_n = 1'b1;
        chk("rel_pos_ready_low", pr, 0);
        tick();
        chk("rel_pos_ready_high", pr, 1);

        // T1
        send(4, 0);
        chk("t1_row0", exp_row(0), {{11{8'h5F}}, 8'h6F, {4{8'h5F}}});
        scan(-1, 0);

        // T2: third frame has ball (12,8), trail (8,4),(4,0)
        send(4, 0);
        scan(-1, 0);
        send(8, 4);
        scan(-1, 0);
        send(12, 8);
        scan(-1, 0);

        // T3: five-cycle stall at row 9
        send(2, 9);
        scan(9, 5);

        // T4: new sample held during SCAN is taken only after the frame
        send(5, 5);
        pv = 1'b1;
        px = 4'd7;
        py = 4'd3;
        scan(-1, 0);
        pv = 1'b0;
        model_push(7, 3);
        chk("t4_accepted_pr", pr, 0);
        chk("t4_accepted_rv", rv, 0);
        tick();
        scan(-1, 0);

        // T5: reset while row 7 is presented
        send(9, 9);
        rr = 1'b1;
        n = 0;
        while (ri !== 4'd7 && n < 20) begin
            tick();
            n++;
        end
        chk("t5_reach_row7", ri, 7);
        rst_n = 1'b0;
        #1;
        chk("t5_rv_async", rv, 0);
        chk("t5_fd", fd, 0);
        chk("t5_fc", fc, 0);
        chk("t5_pr", pr, 0);
        model_clear();
        exp_fc = 8'd0;
        tick();
        tick();
        chk("t5_fd_hold", fd, 0);
        rst_n = 1'b1;
        tick();
        send(1, 1);
        scan(-1, 0);

        // T6: 255 more frames wraps the count to 0
        for (int i = 0; i < 255; i++) begin
            send(i % 16, (i * 7) % 16);
            scan(-1, 0);
        end
        chk("t6_wrap", fc, 0);

        // T6: narrow grid, x out of range draws no ball
        rr8 = 1'b1;
        chk("t6n_ready", pr8, 1);
        pv8 = 1'b1;
        px8 = 4'd15;
        py8 = 4'd15;
        tick();
        pv8 = 1'b0;
        tick();
        for (int r = 15; r >= 0; r--) begin
            chk("t6n_valid", rv8, 1);
            chk("t6n_index", ri8, 128'(r));
            chk("t6n_data", rd8, {8{8'h5F}});
            tick();
        end
        chk("t6n_done", fd8, 1);
        chk("t6n_count", fc8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
